// File: rtl/ysyx_22041412_icache.sv
// Direct-mapped read-only instruction cache: 128-bit lines, two 64-bit bus beats per refill,
// IFU abort handshake (clean_i/clear_o) and whole-cache invalidate for fence.i.
module ysyx_22041412_icache #(
    parameter int unsigned LINES = 64,
    parameter int unsigned TW    = 28 - $clog2(LINES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic [31:0]  addr_i,
    output logic         ready_o,
    output logic [127:0] rdata_o,
    input  logic         clean_i,
    output logic         clear_o,
    input  logic         inval_i,
    output logic         mem_valid_o,
    output logic [31:0]  mem_addr_o,
    input  logic         mem_ready_i,
    input  logic [63:0]  mem_rdata_i
);
    localparam int unsigned IW = $clog2(LINES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL0,
        S_REFILL1,
        S_RESP
    } state_t;

    state_t           state_q;
    logic [27:0]      line_q;
    logic [127:0]     rdata_q;
    logic [63:0]      lo_q;
    logic             abort_q;
    logic             inval_pend_q;
    logic [LINES-1:0] valid_q;
    logic [127:0]     data_q [LINES];
    logic [TW-1:0]    tag_q  [LINES];

    logic [IW-1:0]    idx;
    logic [TW-1:0]    tag;
    logic             hit;
    logic             fill;
    logic             unused_addr;

    assign idx         = line_q[IW-1:0];
    assign tag         = line_q[27:IW];
    assign hit         = valid_q[idx] && (tag_q[idx] == tag);
    assign fill        = (state_q == S_REFILL1) && mem_ready_i;
    assign unused_addr = ^addr_i[3:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            rdata_q      <= '0;
            lo_q         <= '0;
            abort_q      <= 1'b0;
            inval_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            // Latch every invalidate; the IDLE branch below overrides this when it services it.
            if (inval_i) begin
                inval_pend_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    abort_q <= 1'b0;
                    if (clean_i) begin
                        state_q <= S_IDLE;
                    end else if (inval_i || inval_pend_q) begin
                        valid_q      <= '0;
                        inval_pend_q <= 1'b0;
                    end else if (valid_i) begin
                        line_q  <= addr_i[31:4];
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (clean_i) begin
                        state_q <= S_IDLE;
                    end else if (hit) begin
                        rdata_q <= data_q[idx];
                        state_q <= S_RESP;
                    end else begin
                        state_q <= S_REFILL0;
                    end
                end
                S_REFILL0: begin
                    if (clean_i) begin
                        abort_q <= 1'b1;
                    end
                    if (mem_ready_i) begin
                        lo_q    <= mem_rdata_i;
                        state_q <= S_REFILL1;
                    end
                end
                S_REFILL1: begin
                    if (clean_i) begin
                        abort_q <= 1'b1;
                    end
                    // An aborted refill still installs the line but skips the response.
                    if (mem_ready_i) begin
                        valid_q[idx] <= 1'b1;
                        if (abort_q || clean_i) begin
                            state_q <= S_IDLE;
                        end else begin
                            rdata_q <= {mem_rdata_i, lo_q};
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && fill) begin
            data_q[idx] <= {mem_rdata_i, lo_q};
            tag_q[idx]  <= tag;
        end
    end

    always_comb begin
        mem_addr_o = '0;
        case (state_q)
            S_REFILL0: mem_addr_o = {line_q, 4'h0};
            S_REFILL1: mem_addr_o = {line_q, 4'h8};
            default:   mem_addr_o = '0;
        endcase
    end

    assign mem_valid_o = (state_q == S_REFILL0) || (state_q == S_REFILL1);
    assign ready_o     = (state_q == S_RESP) && !clean_i;
    assign rdata_o     = rdata_q;
    assign clear_o     = (state_q == S_IDLE) && !abort_q;

endmodule

// File: tb/tb_ysyx_22041412_icache.sv
// Directed bench for ysyx_22041412_icache: vector table of fetches plus hand-written
// abort, invalidate and reset sequences against a wait-configurable bus model.
module tb_ysyx_22041412_icache;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic         ready_o;
    logic [127:0] rdata_o;
    logic         clean_i = 1'b0;
    logic         clear_o;
    logic         inval_i = 1'b0;
    logic         mem_valid_o;
    logic [31:0]  mem_addr_o;
    logic         mem_ready_i = 1'b0;
    logic [63:0]  mem_rdata_i = '0;

    ysyx_22041412_icache #(.LINES(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .addr_i      (addr_i),
        .ready_o     (ready_o),
        .rdata_o     (rdata_o),
        .clean_i     (clean_i),
        .clear_o     (clear_o),
        .inval_i     (inval_i),
        .mem_valid_o (mem_valid_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned bus_wait = 0;
    int unsigned wcnt = 0;
    int unsigned beats = 0;
    logic [31:0] bus_log[$];

    typedef struct {
        int unsigned wait_cyc;
        logic [31:0] addr;
        bit          miss;
    } vec_t;
    vec_t vecs[11];

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'h5A5AC3C3, a + 32'h01234567};
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:4], 4'h0};
        return {mem_word(b + 32'd8), mem_word(b)};
    endfunction

    // Bus responder: answers each beat after bus_wait idle cycles.
    initial forever begin
        @(negedge clk);
        mem_ready_i = 1'b0;
        if (mem_valid_o === 1'b1) begin
            if (wcnt >= bus_wait) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = mem_word(mem_addr_o);
                bus_log.push_back(mem_addr_o);
                beats++;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fetch(input string name, input logic [31:0] a, input bit miss);
        int unsigned lat;
        int unsigned b0;
        bit          seen;
        bit          clr_low;
        logic [63:0] got;
        b0      = beats;
        bus_log.delete();
        addr_i  = a;
        valid_i = 1'b1;
        lat     = 0;
        seen    = 1'b0;
        clr_low = 1'b1;
        while (!seen && lat < 60) begin
            step();
            lat++;
            if (clear_o !== 1'b0) clr_low = 1'b0;
            if (ready_o === 1'b1) seen = 1'b1;
        end
        valid_i = 1'b0;
        chk({name, " ready"}, 128'(seen), 128'(1));
        chk({name, " latency"}, 128'(lat), 128'(miss ? 4 + 2 * bus_wait : 2));
        chk({name, " data"}, rdata_o, line_of(a));
        chk({name, " beats"}, 128'(beats - b0), 128'(miss ? 2 : 0));
        chk({name, " clear_low"}, 128'(clr_low), 128'(1));
        if (miss) begin
            got = (bus_log.size() == 2) ? {bus_log[0], bus_log[1]} : 64'hFFFF_FFFF_FFFF_FFFF;
            chk({name, " bus_addr"}, 128'(got), 128'({a[31:4], 4'h0, a[31:4], 4'h8}));
        end
        step();
        chk({name, " ready_once"}, 128'(ready_o), 128'(0));
        chk({name, " clear_idle"}, 128'(clear_o), 128'(1));
    endtask

    initial begin
        int unsigned b0;
        int unsigned n;
        bit          rdy_seen;

        vecs[0]  = '{1, 32'h80000004, 1'b1};
        vecs[1]  = '{1, 32'h8000000C, 1'b0};
        vecs[2]  = '{0, 32'h80000000, 1'b0};
        vecs[3]  = '{0, 32'h80000400, 1'b1};
        vecs[4]  = '{0, 32'h80000000, 1'b1};
        vecs[5]  = '{0, 32'h80000400, 1'b1};
        vecs[6]  = '{2, 32'h80000010, 1'b1};
        vecs[7]  = '{0, 32'h8000001F, 1'b0};
        vecs[8]  = '{0, 32'h80000408, 1'b0};
        vecs[9]  = '{0, 32'h800003F0, 1'b1};
        vecs[10] = '{0, 32'h800003F4, 1'b0};

        rst = 1'b0;
        step();
        step();
        chk("rst ready", 128'(ready_o), 128'(0));
        chk("rst rdata", rdata_o, 128'(0));
        chk("rst clear", 128'(clear_o), 128'(1));
        chk("rst mem_valid", 128'(mem_valid_o), 128'(0));
        chk("rst mem_addr", 128'(mem_addr_o), 128'(0));
        rst = 1'b1;
        step();

        for (int unsigned i = 0; i < 11; i++) begin
            bus_wait = vecs[i].wait_cyc;
            fetch($sformatf("v%0d", i), vecs[i].addr, vecs[i].miss);
        end

        // Abort in LOOKUP on a hit: no response ever appears.
        bus_wait = 0;
        addr_i   = 32'h80000010;
        valid_i  = 1'b1;
        step();
        clean_i  = 1'b1;
        valid_i  = 1'b0;
        rdy_seen = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            step();
            clean_i = 1'b0;
            if (ready_o === 1'b1) rdy_seen = 1'b1;
        end
        chk("abort_lookup no_ready", 128'(rdy_seen), 128'(0));
        chk("abort_lookup clear", 128'(clear_o), 128'(1));

        // Abort raised during RESP masks ready_o in that same cycle.
        addr_i  = 32'h80000010;
        valid_i = 1'b1;
        step();
        step();
        clean_i = 1'b1;
        valid_i = 1'b0;
        #1;
        chk("abort_resp ready", 128'(ready_o), 128'(0));
        step();
        clean_i = 1'b0;
        chk("abort_resp clear", 128'(clear_o), 128'(1));

        // Abort during REFILL0: both beats still complete, no response, line installed.
        bus_wait = 2;
        b0       = beats;
        bus_log.delete();
        addr_i   = 32'h80001020;
        valid_i  = 1'b1;
        step();
        step();
        clean_i  = 1'b1;
        valid_i  = 1'b0;
        rdy_seen = 1'b0;
        step();
        clean_i  = 1'b0;
        if (ready_o === 1'b1) rdy_seen = 1'b1;
        n = 0;
        while (beats != b0 + 2 && n < 40) begin
            step();
            n++;
            if (ready_o === 1'b1) rdy_seen = 1'b1;
        end
        chk("abort_refill beats", 128'(beats - b0), 128'(2));
        step();
        if (ready_o === 1'b1) rdy_seen = 1'b1;
        step();
        if (ready_o === 1'b1) rdy_seen = 1'b1;
        chk("abort_refill no_ready", 128'(rdy_seen), 128'(0));
        chk("abort_refill clear", 128'(clear_o), 128'(1));
        fetch("abort_refill_hit", 32'h80001028, 1'b0);

        // Invalidate during a hit LOOKUP: response still delivered, then the line misses.
        bus_wait = 0;
        addr_i   = 32'h80000408;
        valid_i  = 1'b1;
        step();
        inval_i  = 1'b1;
        step();
        inval_i  = 1'b0;
        chk("inval_lookup ready", 128'(ready_o), 128'(1));
        chk("inval_lookup data", rdata_o, line_of(32'h80000408));
        valid_i  = 1'b0;
        step();
        chk("inval_lookup clear", 128'(clear_o), 128'(1));
        step();
        fetch("inval_refill", 32'h80000408, 1'b1);

        // Invalidate with a request in the same IDLE cycle: request is not accepted.
        addr_i  = 32'h80000408;
        valid_i = 1'b1;
        inval_i = 1'b1;
        step();
        inval_i = 1'b0;
        chk("inval_idle noaccept", 128'(clear_o), 128'(1));
        chk("inval_idle no_bus", 128'(mem_valid_o), 128'(0));
        fetch("inval_idle_miss", 32'h80000408, 1'b1);

        // Reset while REFILL1 waits on the bus.
        bus_wait = 3;
        b0       = beats;
        addr_i   = 32'h80002000;
        valid_i  = 1'b1;
        step();
        n = 0;
        while (beats != b0 + 1 && n < 20) begin
            step();
            n++;
        end
        step();
        chk("rst_refill mem_valid", 128'(mem_valid_o), 128'(1));
        chk("rst_refill mem_addr", 128'(mem_addr_o), 128'(32'h80002008));
        rst     = 1'b0;
        valid_i = 1'b0;
        step();
        chk("rst_refill drop", 128'(mem_valid_o), 128'(0));
        chk("rst_refill clear", 128'(clear_o), 128'(1));
        chk("rst_refill ready", 128'(ready_o), 128'(0));
        rst      = 1'b1;
        bus_wait = 0;
        step();
        fetch("rst_refill_miss", 32'h80000408, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
